seq_pattern_tx: RTL and testbench
=================================

// Module: seq_pattern_tx
// PURPOSE
//  Serial bit-pattern transmitter: the generating end of the single-bit serial stream consumed by the sequence detectors.
//  Latches a pattern word plus length and repeat count on a start handshake.
//  Emits the pattern one bit per clock, MSB-first, with per-bit valid and a frame marker.
//  Used as the stimulus source feeding detector inputs and as a standalone serial pattern output.
// PARAMETERS
//  PAT_W  8  maximum pattern length in bits
//  LEN_W  4  width of len port; must hold values 0..PAT_W
//  CNT_W  4  width of repeat count; total frames sent = rpt+1
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      reset, synchronous, active-high
//  start        in   1      request: latch pattern/len/rpt when ready=1
//  pattern      in   PAT_W  pattern word; only bits [len-1:0] used
//  len          in   LEN_W  pattern length, legal 1..PAT_W
//  rpt          in   CNT_W  extra repetitions after first frame
//  abort        in   1      terminate transmission in progress
//  ready        out  1      idle, start accepted this cycle
//  busy         out  1      transmission in progress (= !ready)
//  bit_out      out  1      serial data bit
//  bit_valid    out  1      bit_out carries a pattern bit
//  frame_start  out  1      high with first bit of every frame
//  done         out  1      1-cycle pulse: all frames sent
//  aborted      out  1      1-cycle pulse: abort took effect
//  err          out  1      1-cycle pulse: start with illegal len
// BEHAVIOUR
//  All outputs registered. Reset values:
//   ready=1, busy=0; bit_out, bit_valid, frame_start, done, aborted, err all 0.
//   State IDLE; internal registers cleared.
//  rst has priority over all inputs, in any state, including mid-frame.
//  States: IDLE, SHIFT, GAP, DONE.
//  IDLE:
//   start=1, 1<=len<=PAT_W: latch pattern, len, rpt; set idx=len-1; go SHIFT.
//   start=1, len==0 or len>PAT_W: err=1 next cycle; stay IDLE; nothing latched.
//   abort in IDLE: no effect.
//  SHIFT:
//   Each cycle: bit_valid=1, bit_out=pat[idx]; frame_start=1 only when idx==len-1.
//   idx decrements each bit.
//   After idx==0: rpt_left>0 -> decrement rpt_left, go GAP; else go DONE.
//  GAP:
//   One cycle, bit_valid=0, bit_out=0, then SHIFT with idx=len-1 (frames separated by exactly 1 idle bit).
//  DONE:
//   done=1, bit_valid=0 for one cycle; ready=1 the following cycle; go IDLE.
//  Latency: start sampled in cycle T -> first bit (with frame_start) visible in cycle T+1.
//   Single frame of L bits: last bit in T+L, done in T+L+1, ready in T+L+2.
//   Total: (rpt+1)*L bits + rpt gap cycles.
//  start while busy: ignored; latched values unchanged.
//  abort in SHIFT/GAP/DONE:
//   Next cycle: IDLE with bit_valid=0, frame_start=0, aborted=1, done=0; ready=1 the cycle after.
//   abort coincident with done issued: abort wins.
//  len==PAT_W: full word sent, idx starts at PAT_W-1.
//  rpt = all-ones: 2^CNT_W frames, counter does not wrap early.
//  bit_out=0 whenever bit_valid=0.
// TESTING
//  pattern=8'h0B, len=4, rpt=0, start 1 cycle -> bit_out 1,0,1,1 in T+1..T+4, frame_start@T+1, done@T+5.
//  pattern=8'h05, len=3, rpt=2 -> 101,gap,101,gap,101 (11 cycles); frame_start on 3 cycles; done once.
//  pattern=8'hA5, len=8, rpt=0 -> 1,0,1,0,0,1,0,1; start re-asserted mid-frame ignored.
//  len=0, then len=9 with start -> err pulse each time, ready stays 1, bit_valid stays 0.
//  abort on 2nd bit of len=6 frame -> bit_valid=0 next cycle, aborted=1, no done, ready next.
//  rst asserted mid-SHIFT -> all outputs reset next edge; new start then transmits correctly.
//  Loopback: feed bit_out into detector input; detection pulses match the golden model for 8'h0B.

Source files
------------

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: sends a latched pattern MSB-first, one bit per clock,
// repeated rpt+1 times with a single idle bit between frames.
module seq_pattern_tx #(
   parameter int unsigned PAT_W = 8,
   parameter int unsigned LEN_W = 4,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [LEN_W-1:0] len,
   input  logic [CNT_W-1:0] rpt,
   input  logic             abort,
   output logic             ready,
   output logic             busy,
   output logic             bit_out,
   output logic             bit_valid,
   output logic             frame_start,
   output logic             done,
   output logic             aborted,
   output logic             err
);

   localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state_q, state_n;
   logic [PAT_W-1:0]   pat_q, pat_n;
   logic [LEN_W-1:0]   len_q, len_n;
   logic [CNT_W-1:0]   rpt_q, rpt_n;
   logic [IDX_W-1:0]   idx_q, idx_n;

   logic               ready_n;
   logic               bit_out_n;
   logic               bit_valid_n;
   logic               frame_start_n;
   logic               done_n;
   logic               aborted_n;
   logic               err_n;

   logic               len_ok_c;
   logic [IDX_W-1:0]   first_idx_in_c;
   logic [IDX_W-1:0]   first_idx_q_c;
   logic [IDX_W-1:0]   idx_dec_c;

   // First-bit index for the requested length and for the latched length
   assign len_ok_c       = (len != '0) && (len <= LEN_W'(PAT_W));
   assign first_idx_in_c = IDX_W'(len - LEN_W'(1));
   assign first_idx_q_c  = IDX_W'(len_q - LEN_W'(1));
   assign idx_dec_c      = idx_q - IDX_W'(1);

   // Next-state and next-output logic; outputs describe the cycle after this edge
   always_comb begin
      state_n       = state_q;
      pat_n         = pat_q;
      len_n         = len_q;
      rpt_n         = rpt_q;
      idx_n         = idx_q;
      ready_n       = 1'b0;
      bit_out_n     = 1'b0;
      bit_valid_n   = 1'b0;
      frame_start_n = 1'b0;
      done_n        = 1'b0;
      aborted_n     = 1'b0;
      err_n         = 1'b0;

      case (state_q)
         IDLE: begin
            ready_n = 1'b1;
            // ready is low for one cycle after an abort; start is ignored then
            if (start && ready) begin
               if (len_ok_c) begin
                  pat_n         = pattern;
                  len_n         = len;
                  rpt_n         = rpt;
                  idx_n         = first_idx_in_c;
                  state_n       = SHIFT;
                  ready_n       = 1'b0;
                  bit_valid_n   = 1'b1;
                  frame_start_n = 1'b1;
                  bit_out_n     = pattern[first_idx_in_c];
               end else begin
                  err_n = 1'b1;
               end
            end
         end

         SHIFT: begin
            if (idx_q != '0) begin
               idx_n       = idx_dec_c;
               bit_valid_n = 1'b1;
               bit_out_n   = pat_q[idx_dec_c];
            end else if (rpt_q != '0) begin
               rpt_n   = rpt_q - CNT_W'(1);
               state_n = GAP;
            end else begin
               state_n = DONE;
               done_n  = 1'b1;
            end
         end

         GAP: begin
            state_n       = SHIFT;
            idx_n         = first_idx_q_c;
            bit_valid_n   = 1'b1;
            frame_start_n = 1'b1;
            bit_out_n     = pat_q[first_idx_q_c];
         end

         DONE: begin
            state_n = IDLE;
            ready_n = 1'b1;
         end

         default: begin
            state_n = IDLE;
            ready_n = 1'b1;
         end
      endcase

      // Abort overrides everything, including a done that would otherwise be issued
      if (abort && (state_q != IDLE)) begin
         state_n       = IDLE;
         ready_n       = 1'b0;
         bit_out_n     = 1'b0;
         bit_valid_n   = 1'b0;
         frame_start_n = 1'b0;
         done_n        = 1'b0;
         aborted_n     = 1'b1;
      end
   end

   // State, latched request and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         pat_q       <= '0;
         len_q       <= '0;
         rpt_q       <= '0;
         idx_q       <= '0;
         ready       <= 1'b1;
         busy        <= 1'b0;
         bit_out     <= 1'b0;
         bit_valid   <= 1'b0;
         frame_start <= 1'b0;
         done        <= 1'b0;
         aborted     <= 1'b0;
         err         <= 1'b0;
      end else begin
         state_q     <= state_n;
         pat_q       <= pat_n;
         len_q       <= len_n;
         rpt_q       <= rpt_n;
         idx_q       <= idx_n;
         ready       <= ready_n;
         busy        <= ~ready_n;
         bit_out     <= bit_out_n;
         bit_valid   <= bit_valid_n;
         frame_start <= frame_start_n;
         done        <= done_n;
         aborted     <= aborted_n;
         err         <= err_n;
      end
   end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: cycle-accurate vector table plus multi-cycle sequences.
module tb_seq_pattern_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] pattern;
   logic [3:0] len;
   logic [3:0] rpt;
   logic       abort;
   logic       ready, busy, bit_out, bit_valid, frame_start, done, aborted, err;

   int tests = 0;
   int fails = 0;

   seq_pattern_tx #(.PAT_W(8), .LEN_W(4), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len), .rpt(rpt),
      .abort(abort), .ready(ready), .busy(busy), .bit_out(bit_out), .bit_valid(bit_valid),
      .frame_start(frame_start), .done(done), .aborted(aborted), .err(err)
   );

   always #5 clk = ~clk;

   // Expected output codes: {ready,busy,bit_out,bit_valid,frame_start,done,aborted,err}
   localparam logic [7:0] IDL = 8'h80;
   localparam logic [7:0] ERR = 8'h81;
   localparam logic [7:0] B1F = 8'h78;
   localparam logic [7:0] B0F = 8'h58;
   localparam logic [7:0] B1  = 8'h70;
   localparam logic [7:0] B0  = 8'h50;
   localparam logic [7:0] GP  = 8'h40;
   localparam logic [7:0] DN  = 8'h44;
   localparam logic [7:0] ABT = 8'h42;

   typedef struct {
      logic       rst;
      logic       start;
      logic       abort;
      logic [7:0] pattern;
      logic [3:0] len;
      logic [3:0] rpt;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic s, input logic a, input logic [7:0] p,
                      input logic [3:0] l, input logic [3:0] rp, input logic [7:0] e);
      vec_t v;
      v.rst = r; v.start = s; v.abort = a; v.pattern = p; v.len = l; v.rpt = rp; v.exp = e;
      vecs.push_back(v);
   endtask

   function automatic logic [7:0] outs();
      return {ready, busy, bit_out, bit_valid, frame_start, done, aborted, err};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      rst = 1'b0; start = 1'b0; abort = 1'b0; pattern = 8'h00; len = 4'd0; rpt = 4'd0;
   endtask

   int  fs_cnt, bv_cnt, done_k, det_cnt;
   logic [7:0]  bits_seen;
   logic [3:0]  det_sh;
   logic        seen_done;

   initial begin
      idle_inputs();
      rst = 1'b1;

      // Reset state
      add(1, 0, 0, 8'h00, 0, 0, IDL);
      add(0, 0, 0, 8'h00, 0, 0, IDL);
      // 8'h0B len 4: 1,0,1,1 then done, then ready
      add(0, 1, 0, 8'h0B, 4, 0, B1F);
      add(0, 0, 0, 8'h00, 0, 0, B0);
      add(0, 0, 0, 8'h00, 0, 0, B1);
      add(0, 0, 0, 8'h00, 0, 0, B1);
      add(0, 0, 0, 8'h00, 0, 0, DN);
      add(0, 0, 0, 8'h00, 0, 0, IDL);
      // 8'h05 len 3 rpt 2: 101 gap 101 gap 101
      add(0, 1, 0, 8'h05, 3, 2, B1F);
      add(0, 0, 0, 8'h00, 0, 0, B0);
      add(0, 0, 0, 8'h00, 0, 0, B1);
      add(0, 0, 0, 8'h00, 0, 0, GP);
      add(0, 0, 0, 8'h00, 0, 0, B1F);
      add(0, 0, 0, 8'h00, 0, 0, B0);
      add(0, 0, 0, 8'h00, 0, 0, B1);
      add(0, 0, 0, 8'h00, 0, 0, GP);
      add(0, 0, 0, 8'h00, 0, 0, B1F);
      add(0, 0, 0, 8'h00, 0, 0, B0);
      add(0, 0, 0, 8'h00, 0, 0, B1);
      add(0, 0, 0, 8'h00, 0, 0, DN);
      add(0, 0, 0, 8'h00, 0, 0, IDL);
      // 8'hA5 full width, start re-asserted mid-frame with other values
      add(0, 1, 0, 8'hA5, 8, 0, B1F);
      add(0, 0, 0, 8'h00, 0, 0, B0);
      add(0, 1, 0, 8'hFF, 2, 3, B1);
      add(0, 1, 0, 8'hFF, 2, 3, B0);
      add(0, 0, 0, 8'h00, 0, 0, B0);
      add(0, 0, 0, 8'h00, 0, 0, B1);
      add(0, 0, 0, 8'h00, 0, 0, B0);
      add(0, 0, 0, 8'h00, 0, 0, B1);
      add(0, 0, 0, 8'h00, 0, 0, DN);
      add(0, 0, 0, 8'h00, 0, 0, IDL);
      // Illegal lengths 0, 9, 15
      add(0, 1, 0, 8'hFF, 0, 0, ERR);
      add(0, 0, 0, 8'h00, 0, 0, IDL);
      add(0, 1, 0, 8'hFF, 9, 0, ERR);
      add(0, 0, 0, 8'h00, 0, 0, IDL);
      add(0, 1, 0, 8'hFF, 15, 1, ERR);
      add(0, 0, 0, 8'h00, 0, 0, IDL);
      // Abort on 2nd bit of len 6 (8'h2D = 101101); start in the not-ready cycle ignored
      add(0, 1, 0, 8'h2D, 6, 0, B1F);
      add(0, 0, 0, 8'h00, 0, 0, B0);
      add(0, 0, 1, 8'h00, 0, 0, ABT);
      add(0, 1, 0, 8'h0B, 4, 0, IDL);
      add(0, 0, 0, 8'h00, 0, 0, IDL);
      // Abort in IDLE has no effect
      add(0, 0, 1, 8'h00, 0, 0, IDL);
      // Abort coincident with done: abort wins
      add(0, 1, 0, 8'h02, 2, 0, B1F);
      add(0, 0, 0, 8'h00, 0, 0, B0);
      add(0, 0, 1, 8'h00, 0, 0, ABT);
      add(0, 0, 0, 8'h00, 0, 0, IDL);
      // Abort during the gap
      add(0, 1, 0, 8'h01, 1, 1, B1F);
      add(0, 0, 0, 8'h00, 0, 0, GP);
      add(0, 0, 1, 8'h00, 0, 0, ABT);
      add(0, 0, 0, 8'h00, 0, 0, IDL);
      // Reset mid-SHIFT, then a clean restart
      add(0, 1, 0, 8'h0B, 4, 0, B1F);
      add(0, 0, 0, 8'h00, 0, 0, B0);
      add(1, 0, 0, 8'h00, 0, 0, IDL);
      add(0, 1, 0, 8'h0B, 4, 0, B1F);
      add(0, 0, 0, 8'h00, 0, 0, B0);
      add(0, 0, 0, 8'h00, 0, 0, B1);
      add(0, 0, 0, 8'h00, 0, 0, B1);
      add(0, 0, 0, 8'h00, 0, 0, DN);
      add(0, 0, 0, 8'h00, 0, 0, IDL);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rst = vecs[i].rst; start = vecs[i].start; abort = vecs[i].abort;
         pattern = vecs[i].pattern; len = vecs[i].len; rpt = vecs[i].rpt;
         @(posedge clk);
         #1;
         check($sformatf("vec %0d", i), 32'(outs()), 32'(vecs[i].exp));
      end

      // rpt all-ones: 16 one-bit frames, 15 gaps, done on cycle 32
      @(negedge clk);
      idle_inputs();
      start = 1'b1; pattern = 8'h01; len = 4'd1; rpt = 4'hF;
      fs_cnt = 0; bv_cnt = 0; done_k = 0;
      for (int k = 1; k <= 60 && done_k == 0; k++) begin
         @(posedge clk);
         #1;
         if (k == 1) idle_inputs();
         if (frame_start) fs_cnt++;
         if (bit_valid) bv_cnt++;
         if (!bit_valid && bit_out) check("bit_out_low_when_invalid", 32'(bit_out), 32'd0);
         if (done) done_k = k;
      end
      check("rpt_max_frames", 32'(fs_cnt), 32'd16);
      check("rpt_max_bits", 32'(bv_cnt), 32'd16);
      check("rpt_max_done_cycle", 32'(done_k), 32'd32);
      @(posedge clk);
      #1;
      check("rpt_max_ready_after", 32'(ready), 32'd1);

      // Loopback into a 1011 detector: 8'h0B twice gives stream 10111011, two hits
      @(negedge clk);
      start = 1'b1; pattern = 8'h0B; len = 4'd4; rpt = 4'd1;
      det_sh = 4'h0; det_cnt = 0; bits_seen = 8'h00; bv_cnt = 0; seen_done = 1'b0;
      for (int k = 1; k <= 40 && !seen_done; k++) begin
         @(posedge clk);
         #1;
         if (k == 1) idle_inputs();
         if (bit_valid) begin
            det_sh    = {det_sh[2:0], bit_out};
            bits_seen = {bits_seen[6:0], bit_out};
            bv_cnt++;
            if (det_sh == 4'b1011 && bv_cnt >= 4) det_cnt++;
         end
         if (done) seen_done = 1'b1;
      end
      check("loop_done_seen", 32'(seen_done), 32'd1);
      check("loop_bits", 32'(bits_seen), 32'hBB);
      check("loop_detections", 32'(det_cnt), 32'd2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

endmodule
